// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the read-only SPI master.
package spi_rx_pkg;

  localparam int unsigned SPI_WORD_BITS = 32;
  localparam int unsigned SPI_DIV_W     = 8;
  localparam int unsigned SPI_BIT_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_rx_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: pulses phase_done once every CLK_DIV cycles; load restarts the phase.
module spi_phase_timer
  import spi_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_done
);

  localparam logic [SPI_DIV_W-1:0] LastCnt = SPI_DIV_W'(CLK_DIV - 1);

  logic [SPI_DIV_W-1:0] div_q;

  assign phase_done = (div_q == LastCnt);

  // Count 0..CLK_DIV-1 and wrap, so consecutive phases chain without a gap cycle.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      div_q <= '0;
    end else if (phase_done) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_rx_master.sv
// Read-only SPI master, mode 0, MSB first, fixed 32-bit word.
module spi_rx_master
  import spi_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_ena,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        spi_not_busy,
  output logic [31:0] spi_rx_data
);

  spi_rx_state_t              state_q;
  logic [SPI_WORD_BITS-1:0]   shift_q;
  logic [SPI_BIT_CNT_W-1:0]   bit_cnt_q;
  logic                       phase_done;

  // Timer is held cleared while idle so the first SETUP cycle starts at count 0.
  spi_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == IDLE),
    .phase_done(phase_done)
  );

  // Transaction FSM with registered outputs, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      spi_not_busy <= 1'b1;
      spi_rx_data  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (spi_ena) begin
            state_q      <= SETUP;
            cs_n         <= 1'b0;
            spi_not_busy <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
          end
        end
        SETUP: begin
          if (phase_done) begin
            state_q <= HIGH;
            sclk    <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            shift_q   <= {shift_q[SPI_WORD_BITS-2:0], miso};
            bit_cnt_q <= bit_cnt_q + 6'd1;
            sclk      <= 1'b0;
            if (bit_cnt_q == SPI_BIT_CNT_W'(SPI_WORD_BITS - 1)) begin
              state_q <= HOLD;
            end else begin
              state_q <= LOW;
            end
          end
        end
        LOW: begin
          if (phase_done) begin
            state_q <= HIGH;
            sclk    <= 1'b1;
          end
        end
        HOLD: begin
          if (phase_done) begin
            state_q     <= GAP;
            cs_n        <= 1'b1;
            spi_rx_data <= shift_q;
          end
        end
        GAP: begin
          if (phase_done) begin
            state_q      <= IDLE;
            spi_not_busy <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_master.sv
// Bench for spi_rx_master: two instances (CLK_DIV=2 and CLK_DIV=1) with converter models.
module tb_spi_rx_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ena2 = 1'b1, miso2 = 1'b0, sclk2, cs2, nb2;
  logic        ena1 = 1'b1, miso1 = 1'b0, sclk1, cs1, nb1;
  logic [31:0] rx2, rx1;

  spi_rx_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .spi_ena(ena2), .miso(miso2), .sclk(sclk2), .cs_n(cs2),
    .spi_not_busy(nb2), .spi_rx_data(rx2)
  );

  spi_rx_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .spi_ena(ena1), .miso(miso1), .sclk(sclk1), .cs_n(cs1),
    .spi_not_busy(nb1), .spi_rx_data(rx1)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Converter models: present MSB on CS fall, advance one bit per SCLK fall.
  logic [31:0] word2 = '0, word1 = '0;
  int idx2 = 0, idx1 = 0;
  int rise2 = 0, rise1 = 0;

  always @(negedge cs2) begin idx2 = 0; miso2 = word2[31]; end
  always @(negedge sclk2) if (cs2 === 1'b0) begin
    idx2++;
    if (idx2 < 32) miso2 = word2[31-idx2];
  end
  always @(posedge sclk2) rise2++;

  always @(negedge cs1) begin idx1 = 0; miso1 = word1[31]; end
  always @(negedge sclk1) if (cs1 === 1'b0) begin
    idx1++;
    if (idx1 < 32) miso1 = word1[31-idx1];
  end
  always @(posedge sclk1) rise1++;

  // Last word each instance should be presenting.
  logic [31:0] exp_rx2 = '0, exp_rx1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic get_sclk(input int d); return (d == 1) ? sclk1 : sclk2; endfunction
  function automatic logic get_cs(input int d);   return (d == 1) ? cs1 : cs2;     endfunction
  function automatic logic get_nb(input int d);   return (d == 1) ? nb1 : nb2;     endfunction
  function automatic logic [31:0] get_rx(input int d); return (d == 1) ? rx1 : rx2; endfunction
  function automatic int get_rises(input int d);  return (d == 1) ? rise1 : rise2; endfunction

  task automatic set_ena(input int d, input logic v);
    if (d == 1) ena1 = v; else ena2 = v;
  endtask

  // One full transaction; the expected waveform is derived from the edge-timing formulas.
  task automatic txn(input int d, input logic [31:0] w, input int exp_len);
    int r0, scl_err, cs_err;
    logic exp_sclk, exp_cs;
    logic [31:0] prev;
    scl_err = 0; cs_err = 0;
    prev = (d == 1) ? exp_rx1 : exp_rx2;
    if (d == 1) word1 = w; else word2 = w;
    r0 = get_rises(d);
    @(negedge clk); set_ena(d, 1'b1);
    for (int e = 1; e <= exp_len + 1; e++) begin
      @(posedge clk); #1;
      if (e == 1) set_ena(d, 1'b0);
      exp_sclk = (e >= 1 + d && e < 1 + 65 * d) ? (((e - 1 - d) / d) % 2 == 0) : 1'b0;
      exp_cs   = !(e >= 1 && e < 1 + 65 * d);
      if (get_sclk(d) !== exp_sclk) scl_err++;
      if (get_cs(d) !== exp_cs) cs_err++;
      if (e == 1)          chk("nb_low_at_start", get_nb(d), 1'b0);
      if (e == 65 * d)     chk("rx_held_before_hold_exit", get_rx(d), prev);
      if (e == 1 + 65 * d) chk("rx_word", get_rx(d), w);
      if (e == exp_len)    chk("nb_low_in_gap", get_nb(d), 1'b0);
      if (e == exp_len + 1) chk("nb_back", get_nb(d), 1'b1);
    end
    chk("sclk_rises", get_rises(d) - r0, 32);
    chk("sclk_shape_errs", scl_err, 0);
    chk("cs_shape_errs", cs_err, 0);
    if (d == 1) exp_rx1 = w; else exp_rx2 = w;
  endtask

  typedef struct {
    logic [31:0] word;
    int          d;
    int          exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc, t_rise, t_fall, err, r0;
    logic seen_low;
    logic [31:0] w;
    int d;

    vecs[0] = '{word: 32'hA5C3_0F81, d: 2, exp_len: 132};
    vecs[1] = '{word: 32'h8000_0001, d: 1, exp_len: 66};
    vecs[2] = '{word: 32'h0000_0000, d: 2, exp_len: 132};
    vecs[3] = '{word: 32'hFFFF_FFFF, d: 1, exp_len: 66};

    // Reset held with a pending request: nothing may move.
    r0 = rise2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_cs_n", cs2, 1'b1);
      chk("rst_sclk", sclk2, 1'b0);
      chk("rst_not_busy", nb2, 1'b1);
      chk("rst_rx", rx2, 32'h0);
    end
    chk("rst_no_sclk_edges", rise2 - r0, 0);
    chk("rst_rx_d1", rx1, 32'h0);
    @(negedge clk); rst = 1'b0; ena2 = 1'b0; ena1 = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cs_n", cs2, 1'b1);

    // Table vectors
    foreach (vecs[i]) txn(vecs[i].d, vecs[i].word, vecs[i].exp_len);

    // Random words on random instances
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      d = $urandom_range(1, 2);
      txn(d, w, 66 * d);
    end

    // Held request: back-to-back transactions separated by the gap
    word2 = 32'h1234_5678;
    @(negedge clk); ena2 = 1'b1;
    cyc = 0; t_rise = -1; t_fall = -1; seen_low = 1'b0;
    while (cyc < 600 && t_fall < 0) begin
      @(posedge clk); #1; cyc++;
      if (cs2 === 1'b0 && t_rise < 0) seen_low = 1'b1;
      if (seen_low && t_rise < 0 && cs2 === 1'b1) begin
        t_rise = cyc;
        chk("held_first_word", rx2, 32'h1234_5678);
        word2 = 32'hFFFF_0000;
      end else if (t_rise >= 0 && cs2 === 1'b0) begin
        t_fall = cyc;
      end
    end
    chk("held_gap_cycles", t_fall - t_rise, 3);
    ena2 = 1'b0;
    err = 0; cyc = 0;
    while (cyc < 300 && cs2 !== 1'b1) begin
      if (rx2 !== 32'h1234_5678) err++;
      @(posedge clk); #1; cyc++;
    end
    chk("held_rx_stable_errs", err, 0);
    chk("held_second_word", rx2, 32'hFFFF_0000);
    cyc = 0;
    while (cyc < 50 && nb2 !== 1'b1) begin @(posedge clk); #1; cyc++; end
    chk("held_nb_timeout", cyc < 50, 1'b1);
    exp_rx2 = 32'hFFFF_0000;

    // Sequencer handshake, plus a stray request while SCLK is high
    word2 = 32'hC0DE_1357;
    r0 = rise2;
    @(negedge clk); ena2 = 1'b1;
    cyc = 0;
    while (cyc < 10 && nb2 !== 1'b0) begin @(posedge clk); #1; cyc++; end
    ena2 = 1'b0;
    chk("hs_busy_timeout", cyc < 10, 1'b1);
    cyc = 0;
    while (cyc < 20 && sclk2 !== 1'b1) begin @(posedge clk); #1; cyc++; end
    @(negedge clk); ena2 = 1'b1;
    @(negedge clk); ena2 = 1'b0;
    cyc = 0;
    while (cyc < 300 && nb2 !== 1'b1) begin @(posedge clk); #1; cyc++; end
    chk("hs_done_timeout", cyc < 300, 1'b1);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cs2 !== 1'b1 || nb2 !== 1'b1) err++;
    end
    chk("hs_single_txn_errs", err, 0);
    chk("hs_rises", rise2 - r0, 32);
    chk("hs_word", rx2, 32'hC0DE_1357);
    exp_rx2 = 32'hC0DE_1357;

    // Reset sampled on the bit-10 falling edge (edge 45 for CLK_DIV=2)
    word2 = $urandom;
    @(negedge clk); ena2 = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      @(posedge clk); #1;
      if (e == 1) ena2 = 1'b0;
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cs_n", cs2, 1'b1);
    chk("midrst_rx", rx2, 32'h0);
    chk("midrst_sclk", sclk2, 1'b0);
    chk("midrst_nb", nb2, 1'b1);
    @(negedge clk); rst = 1'b0;
    exp_rx2 = 32'h0;
    exp_rx1 = 32'h0;
    txn(2, 32'h5A3C_E7F0, 132);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt,
             tot_cnt);
    $fatal(1);
  end

endmodule
